// File: rtl/ram_mmio_pkg.sv
`default_nettype none
// =============================================================================
// ram_mmio_pkg : memory-map constants and decode types shared by the RAM/MMIO
//                block and the assembler-side memory map.
// Revision     : 1.0 - initial release
// =============================================================================
package ram_mmio_pkg;

  localparam int c_DATA_WIDTH    = 32;
  localparam int c_ADDRESS_WIDTH = 12;
  localparam int c_DEPTH         = 2 ** c_ADDRESS_WIDTH;
  localparam int c_LED_WIDTH     = 5;

  localparam logic [c_ADDRESS_WIDTH-1:0] c_BTN_ADDR = 12'hFFE;
  localparam logic [c_ADDRESS_WIDTH-1:0] c_LED_ADDR = 12'hFFF;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_BTN = 2'd1,
    REGION_LED = 2'd2
  } region_e;

  // Selects which registered source drives the read port.
  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_MMIO = 1'b1
  } rd_sel_e;

endpackage : ram_mmio_pkg
`default_nettype wire

// File: rtl/mmio_sync2.sv
`default_nettype none
// =============================================================================
// mmio_sync2 : two-flop level synchronizer with asynchronous active-high reset.
//              Compiled only when BTNU_SYNC_EN is defined.
// Revision   : 1.0 - initial release
// =============================================================================
`ifdef BTNU_SYNC_EN
module mmio_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule : mmio_sync2
`endif
`default_nettype wire

// File: rtl/ram_mmio.sv
`default_nettype none
// =============================================================================
// ram_mmio : word-addressed data RAM with BTNU status and LED register mapped
//            over the top two words. Optional macro: BTNU_SYNC_EN.
// Revision : 1.0 - initial release
// =============================================================================
module ram_mmio
  import ram_mmio_pkg::*;
#(
  parameter int                       DATA_WIDTH    = c_DATA_WIDTH,
  parameter int                       ADDRESS_WIDTH = c_ADDRESS_WIDTH,
  parameter int                       DEPTH         = c_DEPTH,
  parameter logic [ADDRESS_WIDTH-1:0] BTN_ADDR      = c_BTN_ADDR,
  parameter logic [ADDRESS_WIDTH-1:0] LED_ADDR      = c_LED_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wEn,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic [DATA_WIDTH-1:0]    dataOut,
  input  logic                     BTNU,
  output logic [c_LED_WIDTH-1:0]   LED
);

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic                   btn;
  region_e                region;
  logic                   ram_we;

  logic [DATA_WIDTH-1:0]  ram_rdata_d;
  logic [DATA_WIDTH-1:0]  ram_rdata_q;
  logic [DATA_WIDTH-1:0]  mmio_d;
  logic [DATA_WIDTH-1:0]  mmio_q;
  rd_sel_e                sel_d;
  rd_sel_e                sel_q;
  logic [c_LED_WIDTH-1:0] led_d;
  logic [c_LED_WIDTH-1:0] led_q;

`ifdef BTNU_SYNC_EN
  mmio_sync2 u_btnu_sync (
    .clk     (clk),
    .rst     (reset),
    .async_i (BTNU),
    .sync_o  (btn)
  );
`else
  assign btn = BTNU;
`endif

  always_comb begin
    region = REGION_RAM;
    if (addr == BTN_ADDR) begin
      region = REGION_BTN;
    end else if (addr == LED_ADDR) begin
      region = REGION_LED;
    end
  end

  // MMIO words shadow RAM: neither BTN_ADDR nor LED_ADDR ever reaches the array.
  always_comb begin
    ram_we      = wEn && (region == REGION_RAM);
    ram_rdata_d = ram[addr];
    sel_d       = (region == REGION_RAM) ? SEL_RAM : SEL_MMIO;

    mmio_d = '0;
    case (region)
      REGION_BTN: mmio_d = {{(DATA_WIDTH-1){1'b0}}, btn};
      REGION_LED: mmio_d = {{(DATA_WIDTH-c_LED_WIDTH){1'b0}}, led_q};
      default:    mmio_d = '0;
    endcase

    led_d = led_q;
    if (wEn && (region == REGION_LED)) begin
      led_d = dataIn[c_LED_WIDTH-1:0];
    end
  end

  // Read data captured from the pre-write array contents: read-before-write.
  always_ff @(posedge clk) begin
    ram_rdata_q <= ram_rdata_d;
  end

  // The array write sits under the reset branch so a write coinciding with reset is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= SEL_MMIO;
      mmio_q <= '0;
      led_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      mmio_q <= mmio_d;
      led_q  <= led_d;
      if (ram_we) begin
        ram[addr] <= dataIn;
      end
    end
  end

  // sel_q resets to the MMIO path, whose register clears, so dataOut is zero during reset.
  assign dataOut = (sel_q == SEL_RAM) ? ram_rdata_q : mmio_q;
  assign LED     = led_q;

endmodule : ram_mmio
`default_nettype wire

// File: tb/tb_ram_mmio.sv
`default_nettype none
// =============================================================================
// tb_ram_mmio : self-checking bench for ram_mmio (scoreboard of expected reads).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_ram_mmio;

  localparam logic [11:0] c_BTN = 12'hFFE;
  localparam logic [11:0] c_LED = 12'hFFF;
`ifdef BTNU_SYNC_EN
  localparam int c_BTN_LAT = 3;
`else
  localparam int c_BTN_LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        wEn;
  logic [11:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        BTNU;
  logic [4:0]  LED;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_ram [int];
  logic [4:0]  m_led;
  logic        m_btn;
  logic [31:0] sb_q [$];

  ram_mmio dut (
    .clk     (clk),
    .reset   (reset),
    .wEn     (wEn),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .BTNU    (BTNU),
    .LED     (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // One bus cycle; when chk is set and the model knows the word, the expected read is queued.
  task automatic cycle(input logic we, input logic [11:0] a, input logic [31:0] d,
                       input bit chk, input string name);
    logic [31:0] exp;
    logic [31:0] got;
    bit          have;
    have = 1'b0;
    exp  = '0;
    if (a == c_BTN) begin
      exp  = {31'b0, m_btn};
      have = 1'b1;
    end else if (a == c_LED) begin
      exp  = {27'b0, m_led};
      have = 1'b1;
    end else if (m_ram.exists(int'(a))) begin
      exp  = m_ram[int'(a)];
      have = 1'b1;
    end
    if (chk && have) sb_q.push_back(exp);
    if (we) begin
      if (a == c_LED) m_led = d[4:0];
      else if (a != c_BTN) m_ram[int'(a)] = d;
    end
    wEn    = we;
    addr   = a;
    dataIn = d;
    @(posedge clk);
    #1;
    wEn = 1'b0;
    if (chk && have) begin
      got = sb_q.pop_front();
      checks++;
      if (dataOut !== got) begin
        errors++;
        $display("FAIL %s addr=%h: dataOut=%h expected=%h", name, a, dataOut, got);
      end
    end
  endtask

  task automatic check_led(input string name);
    checks++;
    if (LED !== m_led) begin
      errors++;
      $display("FAIL %s: LED=%h expected=%h", name, LED, m_led);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (dataOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_dataout: dataOut=%h expected=00000000", dataOut);
    end
    check_led("reset_led");
  endtask

  task automatic test_ram_rw;
    logic [11:0] adrs [4];
    logic [31:0] dats [4];
    adrs = '{12'h000, 12'h123, 12'hFFD, 12'h7FF};
    dats = '{32'hFFFF_FFFF, 32'h0F0F_1234, 32'hCAFE_F00D, 32'h8000_0001};
    cycle(1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, "ram_wr");
    cycle(1'b0, 12'h010, 32'h0, 1'b1, "ram_rd_010");
    for (int i = 0; i < 4; i++) cycle(1'b1, adrs[i], dats[i], 1'b0, "ram_wr");
    for (int i = 0; i < 4; i++) cycle(1'b0, adrs[i], 32'h0, 1'b1, "ram_rd");
  endtask

  task automatic test_led;
    cycle(1'b1, c_LED, 32'h0000_0006, 1'b0, "led_wr");
    check_led("led_after_wr");
    cycle(1'b0, c_LED, 32'h0, 1'b1, "led_rd");
    cycle(1'b1, c_LED, 32'hFFFF_FFE5, 1'b0, "led_wr_wide");
    check_led("led_upper_bits_ignored");
    cycle(1'b0, c_LED, 32'h0, 1'b1, "led_rd_wide");
    cycle(1'b0, 12'h010, 32'h0, 1'b0, "idle");
    check_led("led_hold");
  endtask

  task automatic test_button;
    logic v;
    for (int k = 0; k < 2; k++) begin
      v    = (k == 0);
      BTNU = v;
      for (int i = 0; i < c_BTN_LAT; i++) begin
        m_btn = (i == c_BTN_LAT - 1) ? v : ~v;
        cycle(1'b0, c_BTN, 32'h0, 1'b1, "btn_rd");
      end
    end
  endtask

  task automatic test_btn_write;
    BTNU = 1'b1;
    for (int i = 0; i < c_BTN_LAT + 1; i++) cycle(1'b0, 12'h010, 32'h0, 1'b0, "idle");
    m_btn = 1'b1;
    cycle(1'b1, c_BTN, 32'h0000_1234, 1'b1, "btn_wr_rd");
    check_led("btn_wr_led_unchanged");
    cycle(1'b0, c_BTN, 32'h0, 1'b1, "btn_rd_after_wr");
    BTNU = 1'b0;
    for (int i = 0; i < c_BTN_LAT + 1; i++) cycle(1'b0, 12'h010, 32'h0, 1'b0, "idle");
    m_btn = 1'b0;
    cycle(1'b0, c_BTN, 32'h0, 1'b1, "btn_rd_low");
  endtask

  task automatic test_read_before_write;
    cycle(1'b1, 12'h020, 32'h0000_0005, 1'b0, "rbw_init");
    cycle(1'b1, 12'h020, 32'h0000_000A, 1'b1, "rbw_ram_old");
    cycle(1'b0, 12'h020, 32'h0, 1'b1, "rbw_ram_new");
    cycle(1'b1, c_LED, 32'h0000_0009, 1'b1, "rbw_led_old");
    cycle(1'b0, c_LED, 32'h0, 1'b1, "rbw_led_new");
    check_led("rbw_led_value");
  endtask

  task automatic test_back_to_back;
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 12'h100 + 12'(i * 37);
      cycle(1'b1, a, $urandom, 1'b0, "b2b_wr");
    end
    for (int i = 0; i < 8; i++) begin
      a = 12'h100 + 12'(i * 37);
      cycle(1'b0, a, 32'h0, 1'b1, "b2b_rd");
    end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, c_LED, 32'h0000_001F, 1'b0, "pre_led");
    cycle(1'b1, 12'h030, 32'h0000_0111, 1'b0, "pre_ram");
    cycle(1'b0, c_LED, 32'h0, 1'b1, "pre_led_rd");
    check_led("pre_reset_led");
    #1;
    reset = 1'b1;
    m_led = 5'h0;
    #1;
    checks++;
    if (dataOut !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_dataout: dataOut=%h expected=00000000", dataOut);
    end
    check_led("async_reset_led");
    wEn = 1'b1; addr = 12'h030; dataIn = 32'h0000_0222;
    @(posedge clk);
    #1;
    addr = c_LED; dataIn = 32'h0000_001F;
    @(posedge clk);
    #1;
    check_led("reset_drops_led_wr");
    @(negedge clk);
    wEn   = 1'b0;
    reset = 1'b0;
    cycle(1'b0, 12'h030, 32'h0, 1'b1, "reset_drops_ram_wr");
    check_led("led_after_reset");
    cycle(1'b0, 12'h010, 32'h0, 1'b1, "ram_kept_over_reset");
  endtask

  initial begin
    reset  = 1'b1;
    wEn    = 1'b0;
    addr   = 12'h0;
    dataIn = 32'h0;
    BTNU   = 1'b0;
    m_led  = 5'h0;
    m_btn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    test_ram_rw;
    test_led;
    test_button;
    test_btn_write;
    test_read_before_write;
    test_back_to_back;
    test_async_reset;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram_mmio
`default_nettype wire
